// File: rtl/tennis_pkg.sv
// Shared court definitions for the tennis game blocks (court, players, display).
package tennis_pkg;

    localparam int NUM_POS_DEF = 8;

    typedef enum logic [2:0] {
        CT_IDLE,
        CT_SERVE,
        CT_TO_P2,
        CT_TO_P1,
        CT_POINT
    } court_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Ball step strobe: one-cycle pulse every TICK_DIV cycles while enabled; counter held clear otherwise.
module tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic step
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(TICK_DIV - 1)) begin
            cnt_d = '0;
            step  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ball_court.sv
// Tennis court: moves the ball between the two player ends, judges returns, misses and points.
// Handshake: pX_return is a one-cycle pulse, honoured only in a cycle where pX_hittable is high.
module ball_court
    import tennis_pkg::*;
#(
    parameter int NUM_POS    = NUM_POS_DEF,
    parameter int TICK_DIV   = 25000000,
    parameter int POINT_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_game,
    input  logic               p1_return,
    input  logic               p2_return,
    input  logic               p1_match,
    input  logic               p2_match,
    output logic               p1_hittable,
    output logic               p2_hittable,
    output logic [NUM_POS-1:0] ball_led,
    output logic               server,
    output logic [7:0]         rally_cnt,
    output logic               point_p1,
    output logic               point_p2,
    output court_state_e       dbg_state
);

    localparam int PW = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
    localparam int HW = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;
    localparam logic [PW-1:0] END_P2 = PW'(NUM_POS - 1);

    court_state_e  state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    rally_q, rally_d;
    logic          server_q, server_d;
    logic          p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
    logic          pt1_q, pt1_d, pt2_q, pt2_d;
    logic          step;
    logic [PW-1:0] serve_pos;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q != CT_IDLE),
        .step   (step)
    );

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        hold_d    = hold_q;
        rally_d   = rally_q;
        server_d  = server_q;
        pt1_d     = 1'b0;
        pt2_d     = 1'b0;
        serve_pos = server_q ? END_P2 : '0;

        if (!start_game) begin
            state_d = CT_IDLE;
            pos_d   = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                CT_IDLE: begin
                    state_d = CT_SERVE;
                    pos_d   = serve_pos;
                    rally_d = '0;
                end
                CT_SERVE, CT_TO_P2, CT_TO_P1: begin
                    // Simultaneous losses cancel out: replay the serve, same server.
                    if (p1_match && p2_match) begin
                        state_d = CT_SERVE;
                        pos_d   = serve_pos;
                        rally_d = '0;
                    end else if (p1_match) begin
                        pt2_d = 1'b1;
                    end else if (p2_match) begin
                        pt1_d = 1'b1;
                    end else if (state_q == CT_SERVE) begin
                        if (!server_q && p1_return)     state_d = CT_TO_P2;
                        else if (server_q && p2_return) state_d = CT_TO_P1;
                    end else if (state_q == CT_TO_P2) begin
                        if (p2_return && p2_hit_q) begin
                            state_d = CT_TO_P1;
                            rally_d = sat_inc8(rally_q);
                        end else if (step) begin
                            if (pos_q == END_P2) pt1_d = 1'b1;
                            else                 pos_d = pos_q + 1'b1;
                        end
                    end else begin
                        if (p1_return && p1_hit_q) begin
                            state_d = CT_TO_P2;
                            rally_d = sat_inc8(rally_q);
                        end else if (step) begin
                            if (pos_q == '0) pt2_d = 1'b1;
                            else             pos_d = pos_q - 1'b1;
                        end
                    end
                end
                CT_POINT: begin
                    if (step) begin
                        if (hold_q == HW'(POINT_HOLD - 1)) begin
                            state_d  = CT_SERVE;
                            server_d = ~server_q;
                            pos_d    = server_q ? '0 : END_P2;
                            rally_d  = '0;
                            hold_d   = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                default: state_d = CT_IDLE;
            endcase
            if (pt1_d || pt2_d) begin
                state_d = CT_POINT;
                hold_d  = '0;
            end
        end

        p1_hit_d = (state_d == CT_SERVE && !server_d) || (state_d == CT_TO_P1 && pos_d == '0);
        p2_hit_d = (state_d == CT_SERVE &&  server_d) || (state_d == CT_TO_P2 && pos_d == END_P2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CT_IDLE;
            pos_q    <= '0;
            hold_q   <= '0;
            rally_q  <= '0;
            server_q <= 1'b0;
            p1_hit_q <= 1'b0;
            p2_hit_q <= 1'b0;
            pt1_q    <= 1'b0;
            pt2_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            hold_q   <= hold_d;
            rally_q  <= rally_d;
            server_q <= server_d;
            p1_hit_q <= p1_hit_d;
            p2_hit_q <= p2_hit_d;
            pt1_q    <= pt1_d;
            pt2_q    <= pt2_d;
        end
    end

    always_comb begin
        ball_led = '0;
        if (state_q == CT_SERVE || state_q == CT_TO_P2 || state_q == CT_TO_P1)
            ball_led[pos_q] = 1'b1;
    end

    assign p1_hittable = p1_hit_q;
    assign p2_hittable = p2_hit_q;
    assign server      = server_q;
    assign rally_cnt   = rally_q;
    assign point_p1    = pt1_q;
    assign point_p2    = pt2_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/ball_court.md
BALL_COURT -- requirements
Module: ball_court

Interface
REQ-001 Parameter NUM_POS, 8, number of court positions; pos 0 = P1 end, NUM_POS-1 = P2 end.
REQ-002 Parameter TICK_DIV, 25000000, clk cycles per ball step.
REQ-003 Parameter POINT_HOLD, 4, ball steps spent in POINT before the next serve.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start_game  input  1  level; high = game running, low = forced to IDLE.
REQ-007 p1_return / p2_return  input  1 each  one-cycle return pulse from the player block.
REQ-008 p1_match / p2_match  input  1 each  player-declared loss of point (life exhausted or missed swing).
REQ-009 p1_hittable / p2_hittable  output  1 each  ball in that player's hit window; feeds the player block's hittable_ball input.
REQ-010 ball_led  output  NUM_POS  one-hot ball position; all zero in IDLE and POINT.
REQ-011 server  output  1  0 = P1 serves, 1 = P2 serves.
REQ-012 rally_cnt  output  8  returns in the current rally, saturating at 255.
REQ-013 point_p1 / point_p2  output  1 each  one-cycle pulse when that player wins a point.

Function
REQ-014 States SHALL be IDLE, SERVE, TO_P2, TO_P1, POINT.
REQ-015 Ball SHALL advance one position per step strobe; the strobe is high one clk cycle every TICK_DIV cycles and its counter is held cleared in IDLE.
REQ-016 IDLE -> SERVE on start_game high; any state -> IDLE within one cycle of start_game low.
REQ-017 SERVE: ball held at the server's end; the server's hittable is high; only the server's return SHALL launch the ball (P1 -> TO_P2, P2 -> TO_P1); rally_cnt cleared on entry.
REQ-018 TO_P2: pos increments per step; p2_hittable high only while pos == NUM_POS-1.
REQ-019 TO_P1: pos decrements per step; p1_hittable high only while pos == 0.
REQ-020 A receiver return while its hittable is high SHALL reverse direction next cycle and increment rally_cnt.
REQ-021 A return while hittable is low SHALL be ignored by this block.
REQ-022 A step arriving with the ball at the receiver's end and no return SHALL be a miss: the opponent wins the point.
REQ-023 Return and step in the same cycle at the end position: return wins; no miss.
REQ-024 pX_match high in SERVE/TO_P1/TO_P2 SHALL award the point to the other player; if both are high the same cycle, no point is awarded and the block returns to SERVE with server unchanged.
REQ-025 Point award: exactly one point_pX pulse, enter POINT, all hittable low.
REQ-026 POINT lasts POINT_HOLD steps, then SERVE; server toggles on each exit from POINT.
REQ-027 Hittable outputs SHALL be registered and change only on state/position updates; never both high.

Reset
REQ-028 On rst low: state IDLE, pos 0, server 0, rally_cnt 0, step counter 0, all outputs 0.
REQ-029 Reset assertion mid-rally SHALL abort immediately with no point pulse; release resumes in IDLE.

Structure
REQ-030 Shared package tennis_pkg SHALL hold the court state enumeration and the NUM_POS default, for reuse by the player and display blocks.
REQ-031 Step strobe generation SHALL be a sub-module tick_gen (parameter TICK_DIV, inputs clk/rst/enable, output step).
REQ-032 The block SHALL interoperate with two player blocks: pX_hittable -> hittable_ball, return -> pX_return, match -> pX_match.

Verification (TICK_DIV=4, NUM_POS=8, POINT_HOLD=2)
REQ-033 Serve rally: start_game=1, p1_return in SERVE -> ball_led 0x01 to 0x80 in 7 steps, p2_hittable high at 0x80; p2_return -> TO_P1, rally_cnt=1.
REQ-034 Miss: no p2_return while at 0x80, next step -> point_p1 pulse for 1 cycle, POINT for 2 steps, SERVE with server=1.
REQ-035 Early swing: p2_return at ball_led 0x10 -> ignored, ball continues to 0x80, rally_cnt unchanged.
REQ-036 Tie: p2_return and step in the same cycle at 0x80 -> direction reverses, no point pulse.
REQ-037 Match: p1_match=1 during TO_P2 -> point_p2 pulse; p1_match and p2_match together -> no pulse, SERVE, server unchanged.
REQ-038 Abort: rst low at ball_led 0x08 -> all outputs 0 same cycle; start_game low mid-rally -> IDLE, ball_led 0 next cycle.
